// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared types, constants and helpers for the sensor conditioner
package sensor_pkg;

  // Per-channel conditioning state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } chan_state_t;

  localparam int          SENSOR_WORD_W        = 32;
  localparam logic [31:0] SENSOR_INACTIVE      = 32'hFFFF_FFFF;
  localparam int          DEFAULT_SENS_PER_PAD = 5;
  localparam int          CENTER_IDX           = DEFAULT_SENS_PER_PAD - 1;

  // Index of the bullseye sensor within a pad group of the given size
  function automatic int center_idx(input int sens_per_pad);
    return sens_per_pad - 1;
  endfunction

  // Counter wide enough for either the debounce or the hold interval, plus a spare bit
  function automatic int cnt_width(input int debounce_cycles, input int hold_cycles);
    int m;
    m = (debounce_cycles > hold_cycles) ? debounce_cycles : hold_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// rtl/sensor_channel.sv - synchronise, debounce and stretch one active-low sensor line
module sensor_channel
  import sensor_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 2500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic enable,
  input  logic clear,
  output logic held_n,
  output logic rise
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  chan_state_t            state;
  chan_state_t            nxt_state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       nxt_cnt;

  assign s = sync[SYNC_STAGES-1];

  // Metastability synchroniser; free-running, unaffected by enable or clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Next-state logic: qualify a press, hold a fixed pulse, then qualify the release
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    rise      = 1'b0;
    if (!enable || clear) begin
      nxt_state = ST_IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!s) begin
            nxt_state = ST_QUAL;
            nxt_cnt   = '0;
          end
        end
        ST_QUAL: begin
          if (s) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
          end else if (cnt == DEB_LAST) begin
            nxt_state = ST_HELD;
            nxt_cnt   = '0;
            rise      = 1'b1;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          // Raw level is ignored here so a long press still yields one pulse
          if (cnt == HOLD_LAST) begin
            nxt_state = ST_RELEASE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!s) begin
            nxt_cnt = '0;
          end else if (cnt == DEB_LAST) begin
            nxt_state = ST_IDLE;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CNT_W'(1);
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Looks at the next state so the parent's output register lands in the same cycle as HELD
  assign held_n = (nxt_state != ST_HELD);

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - conditions all pad sensor lines into the controller sensor word
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int NUM_PADS        = 3,
  parameter int SENS_PER_PAD    = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 2500000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PADS*SENS_PER_PAD-1:0] raw_sensor,
  input  logic                             enable,
  input  logic                             clear,
  output logic [SENSOR_WORD_W-1:0]         sensor_output,
  output logic                             hit_valid,
  output logic [NUM_PADS-1:0]              hit_pad_mask,
  output logic [NUM_PADS-1:0]              hit_center
);

  localparam int NUM_CH = NUM_PADS * SENS_PER_PAD;
  localparam int PAD_W  = SENSOR_WORD_W - NUM_CH;
  localparam int CENTER = center_idx(SENS_PER_PAD);

  logic [NUM_CH-1:0]   held_n;
  logic [NUM_CH-1:0]   rise;
  logic [NUM_PADS-1:0] pad_hit;
  logic [NUM_PADS-1:0] center_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      sensor_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES)
      ) u_chan (
        .clock  (clock),
        .reset  (reset),
        .raw    (raw_sensor[gi]),
        .enable (enable),
        .clear  (clear),
        .held_n (held_n[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  // Reduce per-channel rise strobes into per-pad and bullseye hit flags
  always_comb begin
    pad_hit    = '0;
    center_hit = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int k = 0; k < SENS_PER_PAD; k++) begin
        pad_hit[p] = pad_hit[p] | rise[p*SENS_PER_PAD + k];
      end
      center_hit[p] = rise[p*SENS_PER_PAD + CENTER];
    end
  end

  // Output word and hit events, registered together so hits align with the falling bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sensor_output <= SENSOR_INACTIVE;
      hit_valid     <= 1'b0;
      hit_pad_mask  <= '0;
      hit_center    <= '0;
    end else begin
      sensor_output <= {{PAD_W{1'b1}}, held_n};
      hit_valid     <= |pad_hit;
      hit_pad_mask  <= pad_hit;
      hit_center    <= center_hit;
    end
  end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Upstream stage of the VGA/game controller: conditions the 15 raw active-low pad sensor lines (3 pads x 5 sensors) into the 32-bit sensor word that the controller reads each pixel clock.
- Per sensor: synchronise, debounce, and stretch each strike into one fixed-length active-low pulse long enough to be rendered and scored.
- Also emits single-cycle per-pad hit events for the scoring logic.

Parameters:
- NUM_PADS, 3, number of pads.
- SENS_PER_PAD, 5, sensors per pad; index SENS_PER_PAD-1 within each group is the centre (bullseye) sensor.
- SYNC_STAGES, 2, synchroniser depth (>=2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to qualify a press or a release (>=1).
- HOLD_CYCLES, 2500000, length of the stretched output pulse (>=1).

Ports:
- clock  in  1  system clock (VGA pixel clock domain)
- reset  in  1  asynchronous, active-high reset
- raw_sensor  in  NUM_PADS*SENS_PER_PAD (15)  asynchronous sensor lines, 0 = struck
- enable  in  1  1 = conditioning active; 0 = all channels forced idle
- clear  in  1  synchronous one-cycle abort of all channels
- sensor_output  out  32  conditioned word, active-low; bits [14:0] per sensor, bits [31:15] constant 1
- hit_valid  out  1  one-cycle pulse, any pad registered a new hit
- hit_pad_mask  out  NUM_PADS  bit p = pad p registered a new hit this cycle
- hit_center  out  NUM_PADS  bit p = pad p's centre sensor registered a new hit this cycle

Behaviour:
- Reset (async, active-high): synchroniser flops = 1, every channel IDLE, counters = 0, sensor_output = 32'hFFFFFFFF, hit_valid/hit_pad_mask/hit_center = 0.
- Synchroniser: SYNC_STAGES flops per line. It runs regardless of enable or clear. s = last stage.
- Per-channel FSM (states IDLE, QUAL, HELD, RELEASE; counter width $clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES))+1):
  - IDLE: if s==0 -> QUAL, cnt=0.
  - QUAL: if s==1 -> IDLE. Else if cnt==DEBOUNCE_CYCLES-1 -> HELD, cnt=0, raise rise strobe. Else cnt++.
  - HELD: output bit driven 0. cnt++. When cnt==HOLD_CYCLES-1 -> RELEASE, cnt=0. The raw level is ignored while HELD.
  - RELEASE: output bit 1. If s==0 then cnt=0. Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt++.
  - Result: one pulse per physical strike; a sensor held low indefinitely yields exactly one pulse.
- sensor_output is registered: bit i = 0 iff channel i is in HELD.
  - Latency from raw falling (first sampling edge) to output falling = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
  - Pulse width is exactly HOLD_CYCLES cycles.
- Hit events are registered and appear in the same cycle the output bit first goes low:
  - hit_pad_mask[p] = OR of the rise strobes of pad p's channels.
  - hit_center[p] = rise strobe of channel p*SENS_PER_PAD + SENS_PER_PAD-1.
  - hit_valid = |hit_pad_mask.
- Simultaneous rises on several channels or pads: all are reported in the same cycle; no arbitration or queueing. A second channel of the same pad rising while the first is HELD produces a new hit event.
- enable=0: every channel returns to IDLE next edge, cnt=0, outputs inactive, hit outputs 0. Re-enabling with a line still low re-qualifies from scratch: output falls DEBOUNCE_CYCLES+1 edges after enable rises.
- clear=1: same effect as enable=0 for one edge. clear has priority over rise strobes in that cycle.
- Reset mid-pulse truncates the pulse immediately; no hit is re-emitted after reset.

Decomposition:
- Shared package sensor_pkg:
  - channel state enum {IDLE, QUAL, HELD, RELEASE}
  - constants SENSOR_WORD_W=32, SENSOR_INACTIVE=32'hFFFFFFFF, CENTER_IDX=SENS_PER_PAD-1
  - localparam counter-width function
- Sub-module sensor_channel: synchroniser + FSM + counter for one line; outputs held_n and rise. Instantiated NUM_PADS*SENS_PER_PAD times by a generate loop.
- Top level: hit reduction and output register.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10):
- Reset asserted then released, raw all 1 -> sensor_output=32'hFFFFFFFF, hit_valid=0 for 50 cycles.
- raw[4] low for 30 cycles -> sensor_output[4]=0 from edge 7 for exactly 10 cycles. In that first cycle: hit_valid=1, hit_pad_mask=3'b001, hit_center=3'b001. No further pulse while raw[4] stays low.
- raw[9] low for 3 cycles (glitch) -> no output change, hit_valid never asserted.
- raw[0] and raw[14] fall on the same edge -> one hit_valid cycle with hit_pad_mask=3'b101, hit_center=3'b100. Bits 0 and 14 are low for the same 10 cycles.
- raw[7] low; assert reset 3 cycles into HELD -> sensor_output returns to 32'hFFFFFFFF asynchronously. After release with raw[7] still low, a single new hit occurs at edge 7.
- raw[12] low; drop enable during QUAL, restore after 5 cycles with raw[12] still low -> no hit during QUAL. After enable rises, output falls 5 edges later with hit_pad_mask=3'b100, hit_center=3'b000.
